// File: rtl/pi_digit_stream_if.sv
// Digit stream from the pi readout block to the VGA text renderer.
// The master drives a 4-bit digit code with valid; the slave answers with ready.
interface pi_digit_stream_if;
    logic [3:0] dig;
    logic       dig_valid;
    logic       dig_ready;

    modport master (output dig, output dig_valid, input dig_ready);
    modport slave  (input dig, input dig_valid, output dig_ready);
endinterface

// File: rtl/pi_digit_stream.sv
// Walks the pi engine's sum RAM from the integer limb down to limb 0.
// Each base-1000 limb becomes BCD through a serial double-dabble and is streamed out as digit codes.
module pi_digit_stream #(
    parameter int L        = 230,
    parameter int ADR_BITS = 10,
    parameter int N        = 10,
    parameter int RAMDELAY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADR_BITS-1:0] rdadd,
    input  logic [N-1:0]        rdq,
    pi_digit_stream_if.master   dout,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;

    localparam int WCNT_W = $clog2(RAMDELAY + 1);
    localparam int CNT_W  = $clog2(N + 1);
    localparam logic [ADR_BITS-1:0] LAST_ADR  = ADR_BITS'(L - 1);
    localparam logic [WCNT_W-1:0]   WAIT_LAST = WCNT_W'(RAMDELAY - 1);
    localparam logic [CNT_W-1:0]    CONV_LAST = CNT_W'(N - 1);

    logic [2:0]          state_q, state_d;
    logic [ADR_BITS-1:0] rdadd_q, rdadd_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        limb_q, limb_d;
    logic [11:0]         bcd_q, bcd_d;
    logic [1:0]          eidx_q, eidx_d;
    logic [3:0]          dig_q, dig_d;
    logic                dig_valid_q, dig_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_shift;
    logic        is_int;
    logic [1:0]  last_idx;

    // The integer limb shows only its ones digit followed by the decimal point.
    function automatic logic [3:0] digit_at(input logic [11:0] b, input logic int_limb,
                                            input logic [1:0] idx);
        logic [3:0] d;
        if (int_limb) begin
            d = (idx == 2'd0) ? b[3:0] : 4'hA;
        end else begin
            case (idx)
                2'd0:    d = b[11:8];
                2'd1:    d = b[7:4];
                default: d = b[3:0];
            endcase
        end
        return d;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[10:0], limb_q[N-1]};
        is_int    = (rdadd_q == LAST_ADR);
        last_idx  = is_int ? 2'd1 : 2'd2;
    end

    always_comb begin
        state_d     = state_q;
        rdadd_d     = rdadd_q;
        wcnt_d      = wcnt_q;
        cnt_d       = cnt_q;
        limb_d      = limb_q;
        bcd_d       = bcd_q;
        eidx_d      = eidx_q;
        dig_d       = dig_q;
        dig_valid_d = dig_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rdadd_d = LAST_ADR;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    limb_d  = rdq;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CONV: begin
                // A bit leaving the hundreds nibble is a thousands carry: limb was above 999.
                bcd_d  = bcd_shift;
                limb_d = limb_q << 1;
                if (bcd_adj[11]) ovf_d = 1'b1;
                if (cnt_q == CONV_LAST) begin
                    if (is_int && (bcd_shift[11:4] != 8'd0)) ovf_d = 1'b1;
                    eidx_d      = 2'd0;
                    dig_d       = digit_at(bcd_shift, is_int, 2'd0);
                    dig_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (dig_valid_q && dout.dig_ready) begin
                    if (eidx_q == last_idx) begin
                        dig_valid_d = 1'b0;
                        state_d     = S_NEXT;
                    end else begin
                        eidx_d = eidx_q + 2'd1;
                        dig_d  = digit_at(bcd_q, is_int, eidx_q + 2'd1);
                    end
                end
            end
            S_NEXT: begin
                if (rdadd_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rdadd_d = rdadd_q - 1'b1;
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rdadd_q     <= '0;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            limb_q      <= '0;
            bcd_q       <= '0;
            eidx_q      <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdadd_q     <= rdadd_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            limb_q      <= limb_d;
            bcd_q       <= bcd_d;
            eidx_q      <= eidx_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rdadd          = rdadd_q;
    assign dout.dig       = dig_q;
    assign dout.dig_valid = dig_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf            = ovf_q;

endmodule
